led_display_frame_writer: RTL and testbench

Upstream producer for the LED frame RAM. It accepts single-pixel writes (x, y, RGB888) over a valid/ready stream and performs read-modify-write updates into the 64-bit, 13-bit-address frame RAM. It double-buffers the frame. The downstream `led_display_ram_control` scans the front buffer through RAM port A; this block writes only the back buffer through RAM port B. A commit request swaps the two buffers at the next frame boundary.

---
 rtl/led_display_frame_writer_pkg.sv | 23 ++
 rtl/led_display_frame_writer_if.sv | 17 +
 rtl/led_display_frame_writer.sv | 92 +++++++++
 tb/tb_led_display_frame_writer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_display_frame_writer_pkg.sv
// led_display_frame_writer_pkg: shared frame-RAM geometry, pixel type and address map
// Contents:
//    FB_ADDR_W / FB_DATA_W      frame RAM address and word widths
//    FB_TOP_LSB / FB_BOT_LSB    bit offsets of the top-half and bottom-half pixels in a word
//    pixel_rgb_t                packed {r, g, b} pixel
//    fw_state_e                 frame-writer RMW states
//    fb_address()               {2'b00, buffer, row[3:0], col[5:0]}; also used by the RAM controller
package led_display_frame_writer_pkg;
   localparam int FB_ADDR_W  = 13;
   localparam int FB_DATA_W  = 64;
   localparam int FB_TOP_LSB = 0;
   localparam int FB_BOT_LSB = 24;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_rgb_t;
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} fw_state_e;
   function automatic logic [FB_ADDR_W-1:0] fb_address(input logic buf_sel, input logic [3:0] row,
                                                       input logic [5:0] col);
      return {2'b00, buf_sel, row, col};
   endfunction
endpackage

// File: rtl/led_display_frame_writer_if.sv
// led_display_frame_writer_if: single-pixel valid/ready write stream
// Signals:
//    pixel_x_in      column 0..63
//    pixel_y_in      row 0..31
//    pixel_rgb_in    {r, g, b}
//    pixel_valid_in  pixel offered by the producer (master)
//    pixel_ready_out pixel taken by the frame writer (slave) when valid && ready
interface led_display_frame_writer_if;
   import led_display_frame_writer_pkg::*;
   logic [5:0] pixel_x_in;
   logic [4:0] pixel_y_in;
   pixel_rgb_t pixel_rgb_in;
   logic       pixel_valid_in;
   logic       pixel_ready_out;
   modport master (output pixel_x_in, pixel_y_in, pixel_rgb_in, pixel_valid_in, input pixel_ready_out);
   modport slave  (input pixel_x_in, pixel_y_in, pixel_rgb_in, pixel_valid_in, output pixel_ready_out);
endinterface

// File: rtl/led_display_frame_writer.sv
// led_display_frame_writer: read-modify-write pixel updates into the back half of a double-buffered frame RAM
// Ports:
//    clk_in, n_reset_in    clock, synchronous active-low reset
//    pix                   pixel write stream (slave side)
//    commit_in             pulse: back buffer complete, request swap
//    commit_pending_out    swap requested, not yet done
//    frame_sync_in         pulse at start of row 0 from the RAM controller
//    front_buffer_out      buffer being displayed (controller address bit 10)
//    ram_*                 frame RAM port B (address, write data, write enable, read data)
module led_display_frame_writer
   import led_display_frame_writer_pkg::*;
#(
   parameter int NUM_ROW_PIXELS = 32,
   parameter int NUM_COL_PIXELS = 64,
   parameter int RAM_RD_LATENCY = 2
) (
   input  logic                     clk_in,
   input  logic                     n_reset_in,
   led_display_frame_writer_if.slave pix,
   input  logic                     commit_in,
   output logic                     commit_pending_out,
   input  logic                     frame_sync_in,
   output logic                     front_buffer_out,
   output logic [FB_ADDR_W-1:0]     ram_address_out,
   output logic [FB_DATA_W-1:0]     ram_wdata_out,
   output logic                     ram_write_en_out,
   input  logic [FB_DATA_W-1:0]     ram_rdata_in
);
   localparam int X_W = $clog2(NUM_COL_PIXELS);
   localparam int Y_W = $clog2(NUM_ROW_PIXELS);
   fw_state_e            state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [X_W-1:0]       x_q;
   logic [Y_W-1:0]       y_q;
   pixel_rgb_t           rgb_q;
   logic                 back_q;
   logic [FB_DATA_W-1:0] wdata_q, merged;
   logic                 pending_q, front_q;
   logic                 accept, rd_done, swap;

   assign pix.pixel_ready_out = n_reset_in && state_q == S_IDLE && !pending_q;
   assign accept              = pix.pixel_valid_in && pix.pixel_ready_out;
   assign rd_done             = state_q == S_WAIT && cnt_q == 2'd0;
   // A swap only uses a sync seen while the request is already registered and no RMW is in flight.
   assign swap                = pending_q && state_q == S_IDLE && frame_sync_in;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = accept ? S_RD : S_IDLE;
         S_RD:    state_d = S_WAIT;
         S_WAIT:  state_d = rd_done ? S_WR : S_WAIT;
         default: state_d = S_IDLE;
      endcase
      cnt_d = accept ? 2'(RAM_RD_LATENCY - 1) : state_q == S_WAIT ? cnt_q - 2'd1 : cnt_q;
      // Keep the other half of the word as read, replace ours, force the spare bits to zero.
      merged = ram_rdata_in;
      merged[FB_DATA_W-1:48] = '0;
      if (y_q[Y_W-1]) merged[FB_BOT_LSB +: 24] = rgb_q;
      else merged[FB_TOP_LSB +: 24] = rgb_q;
   end

   always_ff @(posedge clk_in) begin
      if (!n_reset_in) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         rgb_q     <= '0;
         back_q    <= 1'b0;
         wdata_q   <= '0;
         pending_q <= 1'b0;
         front_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         x_q       <= accept ? pix.pixel_x_in : x_q;
         y_q       <= accept ? pix.pixel_y_in : y_q;
         rgb_q     <= accept ? pix.pixel_rgb_in : rgb_q;
         back_q    <= accept ? ~front_q : back_q;
         wdata_q   <= rd_done ? merged : wdata_q;
         pending_q <= swap ? 1'b0 : pending_q | commit_in;
         front_q   <= front_q ^ swap;
      end
   end

   assign ram_address_out    = fb_address(back_q, y_q[Y_W-2:0], x_q);
   assign ram_wdata_out      = wdata_q;
   assign ram_write_en_out   = state_q == S_WR;
   assign commit_pending_out = pending_q;
   assign front_buffer_out   = front_q;
endmodule

// File: tb/tb_led_display_frame_writer.sv
// tb_led_display_frame_writer: directed pixel writes with a write scoreboard, commit/swap and reset checks
module tb_led_display_frame_writer;
   import led_display_frame_writer_pkg::*;
   localparam int L = 2;
   typedef struct packed {
      logic [12:0] a;
      logic [63:0] d;
   } wr_t;

   logic        clk_in = 1'b0, n_reset_in = 1'b0, commit_in = 1'b0, frame_sync_in = 1'b0;
   logic        commit_pending_out, front_buffer_out, ram_write_en_out;
   logic [12:0] ram_address_out;
   logic [63:0] ram_wdata_out, ram_rdata_in;
   led_display_frame_writer_if pix();

   led_display_frame_writer #(.RAM_RD_LATENCY(L)) dut (
      .clk_in(clk_in), .n_reset_in(n_reset_in), .pix(pix), .commit_in(commit_in),
      .commit_pending_out(commit_pending_out), .frame_sync_in(frame_sync_in),
      .front_buffer_out(front_buffer_out), .ram_address_out(ram_address_out),
      .ram_wdata_out(ram_wdata_out), .ram_write_en_out(ram_write_en_out), .ram_rdata_in(ram_rdata_in)
   );

   always #5 clk_in = ~clk_in;

   logic [63:0] mem [0:8191];
   logic [63:0] pipe [0:2];
   logic        clr_mem = 1'b1;
   always @(posedge clk_in) begin
      if (clr_mem) for (int i = 0; i < 8192; i++) mem[i] <= '0;
      else if (ram_write_en_out) mem[ram_address_out] <= ram_wdata_out;
      pipe[0] <= mem[ram_address_out];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end
   assign ram_rdata_in = pipe[L-1];

   int cyc = 0, last_acc = 0, we_cnt = 0;
   int acc_t[$];
   always @(posedge clk_in) begin
      cyc <= cyc + 1;
      if (ram_write_en_out) we_cnt <= we_cnt + 1;
      if (pix.pixel_valid_in && pix.pixel_ready_out) begin
         last_acc <= cyc + 1;
         acc_t.push_back(cyc + 1);
      end
   end

   int n_checks = 0, n_fail = 0;
   wr_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk_in) begin
      wr_t e;
      if (ram_write_en_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", {51'd0, ram_address_out}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {51'd0, ram_address_out}, {51'd0, e.a});
            chk("wr_data", ram_wdata_out, e.d);
            chk("wr_latency", 64'(cyc - last_acc), 64'(L + 1));
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input logic [5:0] x, input logic [4:0] y, input logic [23:0] rgb,
                       input logic [12:0] ea, input logic [63:0] ed, input bit push, input bit keep);
      int t;
      pix.pixel_x_in     = x;
      pix.pixel_y_in     = y;
      pix.pixel_rgb_in   = rgb;
      pix.pixel_valid_in = 1'b1;
      if (push) exp_q.push_back('{ea, ed});
      t = 0;
      while (!pix.pixel_ready_out && t < 50) begin
         @(negedge clk_in);
         t++;
      end
      if (t >= 50) chk("ready_timeout", 64'(t), 64'd0);
      @(negedge clk_in);
      if (!keep) pix.pixel_valid_in = 1'b0;
   endtask

   initial begin
      int b, w0, t;
      pix.pixel_valid_in = 1'b0;
      pix.pixel_x_in     = '0;
      pix.pixel_y_in     = '0;
      pix.pixel_rgb_in   = '0;
      repeat (3) @(negedge clk_in);
      chk("ready_in_reset", {63'd0, pix.pixel_ready_out}, 64'd0);
      n_reset_in = 1'b1;
      clr_mem    = 1'b0;
      @(negedge clk_in);
      chk("rst_ready", {63'd0, pix.pixel_ready_out}, 64'd1);
      chk("rst_pending", {63'd0, commit_pending_out}, 64'd0);
      chk("rst_front", {63'd0, front_buffer_out}, 64'd0);
      chk("rst_addr", {51'd0, ram_address_out}, 64'd0);
      chk("rst_wdata", ram_wdata_out, 64'd0);
      chk("rst_we", {63'd0, ram_write_en_out}, 64'd0);
      // top half, then bottom half of the same word
      send(6'd5, 5'd3, 24'h123456, 13'h04C5, 64'h0000_000000_123456, 1, 0);
      send(6'd5, 5'd19, 24'hABCDEF, 13'h04C5, 64'h0000_ABCDEF_123456, 1, 0);
      // back-to-back burst with valid held high
      repeat (6) @(negedge clk_in);
      b  = acc_t.size();
      w0 = we_cnt;
      send(6'd0, 5'd0, 24'h111111, 13'h0400, 64'h0000_000000_111111, 1, 1);
      send(6'd63, 5'd31, 24'h222222, 13'h07FF, 64'h0000_222222_000000, 1, 1);
      send(6'd1, 5'd16, 24'h333333, 13'h0401, 64'h0000_333333_000000, 1, 1);
      send(6'd1, 5'd0, 24'h444444, 13'h0401, 64'h0000_333333_444444, 1, 0);
      repeat (8) @(negedge clk_in);
      chk("burst_gap0", 64'(acc_t[b+1] - acc_t[b]), 64'(L + 3));
      chk("burst_gap1", 64'(acc_t[b+2] - acc_t[b+1]), 64'(L + 3));
      chk("burst_gap2", 64'(acc_t[b+3] - acc_t[b+2]), 64'(L + 3));
      chk("burst_we_cycles", 64'(we_cnt - w0), 64'd4);
      // commit during an RMW, sync ten cycles later
      send(6'd2, 5'd2, 24'h555555, 13'h0482, 64'h0000_000000_555555, 1, 0);
      commit_in = 1'b1;
      @(negedge clk_in);
      commit_in = 1'b0;
      repeat (8) @(negedge clk_in);
      chk("pend_ready", {63'd0, pix.pixel_ready_out}, 64'd0);
      chk("pend_flag", {63'd0, commit_pending_out}, 64'd1);
      @(negedge clk_in);
      frame_sync_in = 1'b1;
      chk("front_before_swap", {63'd0, front_buffer_out}, 64'd0);
      @(negedge clk_in);
      frame_sync_in = 1'b0;
      chk("front_after_swap", {63'd0, front_buffer_out}, 64'd1);
      chk("pend_cleared", {63'd0, commit_pending_out}, 64'd0);
      send(6'd5, 5'd3, 24'h0F0F0F, 13'h00C5, 64'h0000_000000_0F0F0F, 1, 0);
      // commit and sync together: the sync does not count
      repeat (6) @(negedge clk_in);
      commit_in     = 1'b1;
      frame_sync_in = 1'b1;
      @(negedge clk_in);
      commit_in     = 1'b0;
      frame_sync_in = 1'b0;
      chk("same_cycle_front", {63'd0, front_buffer_out}, 64'd1);
      chk("same_cycle_pending", {63'd0, commit_pending_out}, 64'd1);
      repeat (3) @(negedge clk_in);
      frame_sync_in = 1'b1;
      @(negedge clk_in);
      frame_sync_in = 1'b0;
      chk("later_sync_front", {63'd0, front_buffer_out}, 64'd0);
      chk("later_sync_pending", {63'd0, commit_pending_out}, 64'd0);
      // reset while waiting for read data aborts the write
      repeat (4) @(negedge clk_in);
      w0 = we_cnt;
      send(6'd7, 5'd7, 24'h777777, 13'h0000, 64'd0, 0, 0);
      @(negedge clk_in);
      n_reset_in = 1'b0;
      clr_mem    = 1'b1;
      @(negedge clk_in);
      chk("mid_rst_ready", {63'd0, pix.pixel_ready_out}, 64'd0);
      repeat (3) @(negedge clk_in);
      chk("mid_rst_no_write", 64'(we_cnt - w0), 64'd0);
      chk("mid_rst_addr", {51'd0, ram_address_out}, 64'd0);
      chk("mid_rst_wdata", ram_wdata_out, 64'd0);
      chk("mid_rst_front", {63'd0, front_buffer_out}, 64'd0);
      n_reset_in = 1'b1;
      clr_mem    = 1'b0;
      @(negedge clk_in);
      chk("post_rst_ready", {63'd0, pix.pixel_ready_out}, 64'd1);
      send(6'd5, 5'd3, 24'h123456, 13'h04C5, 64'h0000_000000_123456, 1, 0);
      t = 0;
      while (exp_q.size() != 0 && t < 30) begin
         @(negedge clk_in);
         t++;
      end
      repeat (2) @(negedge clk_in);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
